// File: rtl/multi_cycle_ctrl_fsm_if.sv
// Control bus between the multi-cycle RV32I microsequencer (master) and the datapath (slave).
// The sequencer drives the selects and strobes; the datapath returns the opcode, status and memory ready.
interface multi_cycle_ctrl_fsm_if #(
  parameter int CNT_WIDTH = 32
);
  logic [6:0]           opcode;
  logic                 alu_bcond;
  logic                 mem_ready;
  logic                 halt_cond;

  logic                 pc_write;
  logic                 pc_source;
  logic                 iord;
  logic                 mem_read;
  logic                 mem_write;
  logic                 ir_write;
  logic                 reg_write;
  logic [1:0]           wb_sel;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op_sel;
  logic                 is_ecall;
  logic                 illegal_inst;
  logic                 halted;
  logic                 mem_timeout;
  logic [3:0]           cur_state;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] retired_count;

  modport master (
    input  opcode, alu_bcond, mem_ready, halt_cond,
    output pc_write, pc_source, iord, mem_read, mem_write, ir_write, reg_write,
           wb_sel, alu_src_a, alu_src_b, alu_op_sel, is_ecall, illegal_inst,
           halted, mem_timeout, cur_state, cycle_count, retired_count
  );

  modport slave (
    output opcode, alu_bcond, mem_ready, halt_cond,
    input  pc_write, pc_source, iord, mem_read, mem_write, ir_write, reg_write,
           wb_sel, alu_src_a, alu_src_b, alu_op_sel, is_ecall, illegal_inst,
           halted, mem_timeout, cur_state, cycle_count, retired_count
  );
endinterface

// File: rtl/multi_cycle_ctrl_fsm.sv
// Microsequencer for the multi-cycle RV32I core: IF/ID/EX/MEM/WB stepping, memory-wait watchdog, ECALL halt.
// Define CTRL_PERF_COUNTERS_EN to build the cycle/retired performance counters; otherwise they read 0.
module multi_cycle_ctrl_fsm #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  multi_cycle_ctrl_fsm_if.master bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [8:0]           WAIT_LIMIT = 9'(MEM_WAIT_MAX);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EX      = 4'd2,
    S_JALR_PC = 4'd3,
    S_MEM     = 4'd4,
    S_WB      = 4'd5,
    S_PC4     = 4'd6,
    S_HALT    = 4'd7
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op_sel;
    logic       is_ecall;
    logic       illegal_inst;
  } ctl_t;

  state_e               r_state;
  state_e               w_next_state;
  logic [7:0]           r_wait_cnt;
  logic                 r_mem_timeout;
  logic                 w_waiting;
  logic [8:0]           w_wait_inc;
  logic                 w_wd_expire;
  ctl_t                 w_ctl;
  ctl_t                 w_out;
  logic [CNT_WIDTH-1:0] w_cycle_count;
  logic [CNT_WIDTH-1:0] w_retired_count;

  // Watchdog: consecutive un-ready cycles spent in IF or MEM; ready on the limit cycle wins.
  assign w_waiting   = ((r_state == S_IF) || (r_state == S_MEM)) && !bus.mem_ready;
  assign w_wait_inc  = {1'b0, r_wait_cnt} + 9'd1;
  assign w_wd_expire = w_waiting && (w_wait_inc >= WAIT_LIMIT);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop reading the pre-edge values of its peers.
    if (reset) begin
      r_state       <= S_IF;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_wait_cnt    <= (w_waiting && !w_wd_expire) ? w_wait_inc[7:0] : 8'd0;
      if (w_wd_expire) r_mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    w_ctl        = '0;
    w_next_state = r_state;
    unique case (r_state)
      S_IF: begin
        w_ctl.mem_read = 1'b1;
        if (bus.mem_ready) begin
          w_ctl.ir_write = 1'b1;
          w_next_state   = S_ID;
        end else if (w_wd_expire) begin
          w_next_state = S_HALT;
        end
      end
      S_ID: begin
        w_ctl.alu_src_b = 2'd2;
        case (bus.opcode)
          OP_SYSTEM: begin
            w_ctl.is_ecall = 1'b1;
            w_next_state   = bus.halt_cond ? S_HALT : S_PC4;
          end
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: w_next_state = S_EX;
          default: begin
            w_ctl.illegal_inst = 1'b1;
            w_next_state       = S_PC4;
          end
        endcase
      end
      S_EX: begin
        case (bus.opcode)
          OP_R: begin
            w_ctl.alu_src_a  = 1'b1;
            w_ctl.alu_op_sel = 2'd1;
            w_next_state     = S_WB;
          end
          OP_I: begin
            w_ctl.alu_src_a  = 1'b1;
            w_ctl.alu_src_b  = 2'd2;
            w_ctl.alu_op_sel = 2'd1;
            w_next_state     = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            w_ctl.alu_src_a = 1'b1;
            w_ctl.alu_src_b = 2'd2;
            w_next_state    = S_MEM;
          end
          OP_BRANCH: begin
            w_ctl.alu_src_a  = 1'b1;
            w_ctl.alu_op_sel = 2'd2;
            w_ctl.pc_source  = 1'b1;
            w_ctl.pc_write   = bus.alu_bcond;
            w_next_state     = bus.alu_bcond ? S_IF : S_PC4;
          end
          OP_JAL: begin
            // rd <= PC+4 straight off the ALU while PC loads the PC+imm held in ALUOut.
            w_ctl.alu_src_b = 2'd1;
            w_ctl.reg_write = 1'b1;
            w_ctl.pc_write  = 1'b1;
            w_ctl.pc_source = 1'b1;
            w_next_state    = S_IF;
          end
          OP_JALR: begin
            w_ctl.alu_src_b = 2'd1;
            w_ctl.reg_write = 1'b1;
            w_next_state    = S_JALR_PC;
          end
          default: w_next_state = S_PC4;
        endcase
      end
      S_JALR_PC: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = 2'd2;
        w_ctl.pc_write  = 1'b1;
        w_next_state    = S_IF;
      end
      S_MEM: begin
        w_ctl.iord      = 1'b1;
        w_ctl.mem_read  = (bus.opcode == OP_LOAD);
        w_ctl.mem_write = (bus.opcode == OP_STORE);
        if (bus.mem_ready) begin
          w_next_state = (bus.opcode == OP_LOAD) ? S_WB : S_PC4;
        end else if (w_wd_expire) begin
          w_next_state = S_HALT;
        end
      end
      S_WB: begin
        w_ctl.reg_write = 1'b1;
        w_ctl.wb_sel    = (bus.opcode == OP_LOAD) ? 2'd2 : 2'd1;
        w_ctl.alu_src_b = 2'd1;
        w_ctl.pc_write  = 1'b1;
        w_next_state    = S_IF;
      end
      S_PC4: begin
        w_ctl.alu_src_b = 2'd1;
        w_ctl.pc_write  = 1'b1;
        w_next_state    = S_IF;
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_IF;
    endcase
  end

`ifdef CTRL_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] r_cycle_cnt;
  logic [CNT_WIDTH-1:0] r_retired_cnt;
  logic                 w_halt_entry;

  assign w_halt_entry = (w_next_state == S_HALT) && (r_state != S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
    end else begin
      if ((r_state != S_HALT) && !(&r_cycle_cnt)) r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
      if ((w_ctl.pc_write || w_halt_entry) && !(&r_retired_cnt)) begin
        r_retired_cnt <= r_retired_cnt + CNT_ONE;
      end
    end
  end

  assign w_cycle_count   = r_cycle_cnt;
  assign w_retired_count = r_retired_cnt;
`else
  assign w_cycle_count   = CNT_ONE ^ CNT_ONE;
  assign w_retired_count = {CNT_WIDTH{1'b0}};
`endif

  // Every output reads 0 while reset is held, regardless of the pre-reset state.
  assign w_out             = reset ? '0 : w_ctl;
  assign bus.pc_write      = w_out.pc_write;
  assign bus.pc_source     = w_out.pc_source;
  assign bus.iord          = w_out.iord;
  assign bus.mem_read      = w_out.mem_read;
  assign bus.mem_write     = w_out.mem_write;
  assign bus.ir_write      = w_out.ir_write;
  assign bus.reg_write     = w_out.reg_write;
  assign bus.wb_sel        = w_out.wb_sel;
  assign bus.alu_src_a     = w_out.alu_src_a;
  assign bus.alu_src_b     = w_out.alu_src_b;
  assign bus.alu_op_sel    = w_out.alu_op_sel;
  assign bus.is_ecall      = w_out.is_ecall;
  assign bus.illegal_inst  = w_out.illegal_inst;
  assign bus.halted        = !reset && (r_state == S_HALT);
  assign bus.mem_timeout   = !reset && r_mem_timeout;
  assign bus.cur_state     = reset ? 4'd0 : r_state;
  assign bus.cycle_count   = reset ? '0 : w_cycle_count;
  assign bus.retired_count = reset ? '0 : w_retired_count;

endmodule

// File: tb/tb_multi_cycle_ctrl_fsm.sv
// Self-checking bench for multi_cycle_ctrl_fsm: an instruction-level model expands each opcode into its
// expected per-cycle control words; directed cases first, then randomized opcodes, waits and branch outcomes.
module tb_multi_cycle_ctrl_fsm;

  localparam int WAIT_MAX = 4;
  localparam int CW       = 32;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_SYS  = 7'b1110011;

  localparam int ST_IF = 0, ST_ID = 1, ST_EX = 2, ST_JALR_PC = 3;
  localparam int ST_MEM = 4, ST_WB = 5, ST_PC4 = 6, ST_HALT = 7;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic       pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] op_sel;
    logic       is_ecall;
    logic       illegal;
    logic       halted;
    logic       timeout;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_cycle_ctrl_fsm_if #(.CNT_WIDTH(CW)) bus ();

  multi_cycle_ctrl_fsm #(.MEM_WAIT_MAX(WAIT_MAX), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: counters as they should read at the start of the current cycle.
  longint m_cycles;
  longint m_retired;
  bit     m_timeout;
  int     m_prev_st;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic bit known(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_SYS};
  endfunction

  function automatic ctl_t observe();
    ctl_t c;
    c.st        = bus.cur_state;
    c.pc_write  = bus.pc_write;
    c.pc_source = bus.pc_source;
    c.iord      = bus.iord;
    c.mem_read  = bus.mem_read;
    c.mem_write = bus.mem_write;
    c.ir_write  = bus.ir_write;
    c.reg_write = bus.reg_write;
    c.wb_sel    = bus.wb_sel;
    c.src_a     = bus.alu_src_a;
    c.src_b     = bus.alu_src_b;
    c.op_sel    = bus.alu_op_sel;
    c.is_ecall  = bus.is_ecall;
    c.illegal   = bus.illegal_inst;
    c.halted    = bus.halted;
    c.timeout   = bus.mem_timeout;
    return c;
  endfunction

  function automatic ctl_t at(input int s);
    ctl_t c = '0;
    c.st      = 4'(s);
    c.halted  = (s == ST_HALT);
    c.timeout = m_timeout;
    return c;
  endfunction

  // PC <= PC + 4 through the ALU: operand A = PC, operand B = 4, forced ADD, PC from ALU result.
  function automatic ctl_t bump_pc(input int s);
    ctl_t c = at(s);
    c.src_b    = 2'd1;
    c.pc_write = 1'b1;
    return c;
  endfunction

  task automatic check_counters(input string tag);
`ifdef CTRL_PERF_COUNTERS_EN
    check({tag, ".cycles"},  64'(bus.cycle_count),   64'(m_cycles));
    check({tag, ".retired"}, 64'(bus.retired_count), 64'(m_retired));
`else
    check({tag, ".cycles"},  64'(bus.cycle_count),   64'd0);
    check({tag, ".retired"}, 64'(bus.retired_count), 64'd0);
`endif
  endtask

  // One clock: drive inputs on the falling edge, sample 1 ns later, then let the rising edge happen.
  task automatic cyc(input string tag, input ctl_t e, input logic [6:0] op,
                     input logic rdy, input logic bc, input logic hc);
    string t;
    @(negedge clk);
    reset         = 1'b0;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    bus.alu_bcond = bc;
    bus.halt_cond = hc;
    #1;
    if (e.st == 4'(ST_HALT) && m_prev_st != ST_HALT) m_retired++;
    t = $sformatf("%s.s%0d", tag, e.st);
    check(t, 64'(observe()), 64'(e));
    check_counters(t);
    if (e.st != 4'(ST_HALT)) m_cycles++;
    if (e.pc_write) m_retired++;
    m_prev_st = int'(e.st);
  endtask

  task automatic do_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset         = 1'b1;
      bus.opcode    = 7'($urandom);
      bus.mem_ready = rb();
      bus.alu_bcond = rb();
      bus.halt_cond = rb();
      #1;
      check({tag, ".rst"}, 64'(observe()), 64'd0);
      check({tag, ".rst.cycles"},  64'(bus.cycle_count),   64'd0);
      check({tag, ".rst.retired"}, 64'(bus.retired_count), 64'd0);
    end
    m_cycles  = 0;
    m_retired = 0;
    m_timeout = 1'b0;
    m_prev_st = ST_IF;
  endtask

  task automatic halt_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, at(ST_HALT), 7'($urandom), rb(), rb(), rb());
  endtask

  // Runs one instruction through the model; halted=1 when it ends in HALT (caller must reset).
  task automatic run_inst(input string tag, input logic [6:0] op, input int if_w, input int mem_w,
                          input logic bc, input logic hc, output bit halted);
    ctl_t e;
    halted = 1'b0;
    for (int i = 0; i < if_w; i++) begin
      e = at(ST_IF);
      e.mem_read = 1'b1;
      cyc(tag, e, 7'($urandom), 1'b0, rb(), rb());
      if (i + 1 == WAIT_MAX) begin
        m_timeout = 1'b1;
        halt_cycles(tag, 3);
        halted = 1'b1;
        return;
      end
    end
    e = at(ST_IF);
    e.mem_read = 1'b1;
    e.ir_write = 1'b1;
    cyc(tag, e, 7'($urandom), 1'b1, rb(), rb());

    e = at(ST_ID);
    e.src_b    = 2'd2;
    e.is_ecall = (op == OP_SYS);
    e.illegal  = !known(op);
    cyc(tag, e, op, rb(), rb(), hc);
    if (op == OP_SYS && hc) begin
      halt_cycles(tag, 20);
      halted = 1'b1;
      return;
    end
    if (op == OP_SYS || !known(op)) begin
      cyc(tag, bump_pc(ST_PC4), op, rb(), rb(), rb());
      return;
    end

    e = at(ST_EX);
    case (op)
      OP_R:         begin e.src_a = 1'b1; e.op_sel = 2'd1; end
      OP_I:         begin e.src_a = 1'b1; e.src_b = 2'd2; e.op_sel = 2'd1; end
      OP_LD, OP_ST: begin e.src_a = 1'b1; e.src_b = 2'd2; end
      OP_BR:        begin e.src_a = 1'b1; e.op_sel = 2'd2; e.pc_source = 1'b1; e.pc_write = bc; end
      default: begin
        e.src_b     = 2'd1;
        e.reg_write = 1'b1;
        e.pc_write  = (op == OP_JAL);
        e.pc_source = (op == OP_JAL);
      end
    endcase
    cyc(tag, e, op, rb(), (op == OP_BR) ? bc : rb(), rb());

    case (op)
      OP_R, OP_I: begin
        e = bump_pc(ST_WB);
        e.reg_write = 1'b1;
        e.wb_sel    = 2'd1;
        cyc(tag, e, op, rb(), rb(), rb());
      end
      OP_BR: if (!bc) cyc(tag, bump_pc(ST_PC4), op, rb(), rb(), rb());
      OP_JALR: begin
        e = at(ST_JALR_PC);
        e.src_a    = 1'b1;
        e.src_b    = 2'd2;
        e.pc_write = 1'b1;
        cyc(tag, e, op, rb(), rb(), rb());
      end
      OP_LD, OP_ST: begin
        e = at(ST_MEM);
        e.iord      = 1'b1;
        e.mem_read  = (op == OP_LD);
        e.mem_write = (op == OP_ST);
        for (int i = 0; i < mem_w; i++) begin
          cyc(tag, e, op, 1'b0, rb(), rb());
          if (i + 1 == WAIT_MAX) begin
            m_timeout = 1'b1;
            halt_cycles(tag, 3);
            halted = 1'b1;
            return;
          end
        end
        cyc(tag, e, op, 1'b1, rb(), rb());
        if (op == OP_LD) begin
          e = bump_pc(ST_WB);
          e.reg_write = 1'b1;
          e.wb_sel    = 2'd2;
        end else begin
          e = bump_pc(ST_PC4);
        end
        cyc(tag, e, op, rb(), rb(), rb());
      end
      default: ;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit reached before the summary line");
    $fatal(1, "time limit");
  end

  initial begin
    logic [6:0] ops [8];
    logic [6:0] op;
    ctl_t       e;
    bit         h;
    int         if_w, mem_w;

    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_SYS};
    reset         = 1'b1;
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;
    bus.alu_bcond = 1'b0;
    bus.halt_cond = 1'b0;

    do_reset("init");
    run_inst("add",       OP_R,    0, 0,            1'b0, 1'b0, h);
    run_inst("load_w3",   OP_LD,   0, WAIT_MAX - 1, 1'b0, 1'b0, h);
    run_inst("beq_taken", OP_BR,   0, 0,            1'b1, 1'b0, h);
    run_inst("bne_fall",  OP_BR,   0, 0,            1'b0, 1'b0, h);
    run_inst("jalr",      OP_JALR, 0, 0,            1'b0, 1'b0, h);
    run_inst("jal",       OP_JAL,  1, 0,            1'b0, 1'b0, h);
    run_inst("store",     OP_ST,   2, 1,            1'b0, 1'b0, h);
    run_inst("addi",      OP_I,    WAIT_MAX - 1, 0, 1'b0, 1'b0, h);
    run_inst("illegal",   7'h7f,   0, 0,            1'b0, 1'b0, h);
    run_inst("ecall_go",  OP_SYS,  0, 0,            1'b0, 1'b0, h);
    run_inst("ecall_hlt", OP_SYS,  0, 0,            1'b0, 1'b1, h);
    do_reset("after_ecall");
    run_inst("add2",      OP_R,    0, 0,            1'b0, 1'b0, h);
    do_reset("pre_if_to");
    run_inst("if_timeout", OP_R,   WAIT_MAX, 0,     1'b0, 1'b0, h);
    do_reset("after_if_to");
    run_inst("mem_timeout", OP_ST, 0, WAIT_MAX,     1'b0, 1'b0, h);
    do_reset("after_mem_to");

    // Reset in the middle of a stalled load aborts it; the next fetch starts clean.
    e = at(ST_IF); e.mem_read = 1'b1; e.ir_write = 1'b1;
    cyc("abort", e, OP_LD, 1'b1, 1'b0, 1'b0);
    e = at(ST_ID); e.src_b = 2'd2;
    cyc("abort", e, OP_LD, 1'b0, 1'b0, 1'b0);
    e = at(ST_EX); e.src_a = 1'b1; e.src_b = 2'd2;
    cyc("abort", e, OP_LD, 1'b0, 1'b0, 1'b0);
    e = at(ST_MEM); e.iord = 1'b1; e.mem_read = 1'b1;
    cyc("abort", e, OP_LD, 1'b0, 1'b0, 1'b0);
    do_reset("abort");
    run_inst("post_abort", OP_LD, 0, WAIT_MAX - 1, 1'b0, 1'b0, h);

    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 7'($urandom);
        while (known(op) || op == 7'b0110111 || op == 7'b0010111);
      end else begin
        op = ops[$urandom_range(0, 7)];
      end
      if_w  = ($urandom_range(0, 15) == 0) ? WAIT_MAX : $urandom_range(0, WAIT_MAX - 1);
      mem_w = ($urandom_range(0, 15) == 0) ? WAIT_MAX : $urandom_range(0, WAIT_MAX - 1);
      run_inst($sformatf("rnd%0d", n), op, if_w, mem_w, rb(), ($urandom_range(0, 3) == 0), h);
      if (h) do_reset($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
